// File: rtl/riscv_defs_pkg.sv
// rtl/riscv_defs_pkg.sv - RV32I opcodes, ALU codes, immediate types and control bundle (DECODE_MEXT_EN widens alu_op)
package riscv_defs_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // Eleven base codes fit in 4 bits; the eight M-extension codes push the field to 5 bits.
`ifdef DECODE_MEXT_EN
   localparam int ALUOP_W = 5;
`else
   localparam int ALUOP_W = 4;
`endif

   typedef logic [ALUOP_W-1:0] alu_op_t;

   localparam alu_op_t ALU_ADD   = alu_op_t'(0);
   localparam alu_op_t ALU_SUB   = alu_op_t'(1);
   localparam alu_op_t ALU_SLL   = alu_op_t'(2);
   localparam alu_op_t ALU_SLT   = alu_op_t'(3);
   localparam alu_op_t ALU_SLTU  = alu_op_t'(4);
   localparam alu_op_t ALU_XOR   = alu_op_t'(5);
   localparam alu_op_t ALU_SRL   = alu_op_t'(6);
   localparam alu_op_t ALU_SRA   = alu_op_t'(7);
   localparam alu_op_t ALU_OR    = alu_op_t'(8);
   localparam alu_op_t ALU_AND   = alu_op_t'(9);
   // LUI: result is operand B (the U immediate) unchanged
   localparam alu_op_t ALU_COPYB = alu_op_t'(10);
`ifdef DECODE_MEXT_EN
   // M codes are 16 + funct3, in funct3 order
   localparam alu_op_t ALU_MUL    = alu_op_t'(16);
   localparam alu_op_t ALU_MULH   = alu_op_t'(17);
   localparam alu_op_t ALU_MULHSU = alu_op_t'(18);
   localparam alu_op_t ALU_MULHU  = alu_op_t'(19);
   localparam alu_op_t ALU_DIV    = alu_op_t'(20);
   localparam alu_op_t ALU_DIVU   = alu_op_t'(21);
   localparam alu_op_t ALU_REM    = alu_op_t'(22);
   localparam alu_op_t ALU_REMU   = alu_op_t'(23);
`endif

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

   typedef struct packed {
      alu_op_t alu_op;
      logic    alu_src_imm;
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    branch;
      logic    jump;
      logic    illegal;
   } ctrl_t;

   // Shared OP / OP-IMM funct3 mapping; alt selects SUB/SRA (instruction bit 30)
   function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational RV32I immediate extraction and sign extension
import riscv_defs_pkg::*;

module imm_gen (
   input  logic [31:0] inst,
   input  imm_type_e   imm_type,
   output logic [31:0] imm
);

   // select the immediate layout; all formats sign-extend from inst[31]
   always_comb begin
      imm = '0;
      case (imm_type)
         IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm = {inst[31:12], 12'b0};
         IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = {{20{inst[31]}}, inst[31:20]};
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with valid/ready pipeline register and flush (DECODE_MEXT_EN adds RV32M)
import riscv_defs_pkg::*;

module decode_stage #(
   parameter int XLEN    = 32,
   parameter int ALUOP_W = riscv_defs_pkg::ALUOP_W
) (
   input  logic               clk1,
   input  logic               rst,
   input  logic [31:0]        in_IR,
   input  logic [XLEN-1:0]    in_PC,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_PC,
   output logic [4:0]         rs1_addr,
   output logic [4:0]         rs2_addr,
   output logic [4:0]         rd_addr,
   output logic [XLEN-1:0]    imm,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               alu_src_imm,
   output logic               reg_write,
   output logic               mem_read,
   output logic               mem_write,
   output logic               branch,
   output logic               jump,
   output logic               illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   imm_type_e  imm_type;
   logic [31:0] imm_d;
   ctrl_t      ctrl_d;
   ctrl_t      ctrl_q;
   logic       xfer;

   assign opcode = in_IR[6:0];
   assign funct3 = in_IR[14:12];
   assign funct7 = in_IR[31:25];

   assign in_ready = !out_valid || out_ready;
   assign xfer     = in_valid && in_ready;

   imm_gen u_imm_gen (
      .inst     (in_IR),
      .imm_type (imm_type),
      .imm      (imm_d)
   );

   // decode opcode/funct fields into the control bundle and immediate format
   always_comb begin
      ctrl_d   = '0;
      imm_type = IMM_I;
      case (opcode)
         OPC_LUI: begin
            imm_type           = IMM_U;
            ctrl_d.alu_op      = ALU_COPYB;
            ctrl_d.alu_src_imm = 1'b1;
            ctrl_d.reg_write   = 1'b1;
         end
         OPC_AUIPC: begin
            imm_type           = IMM_U;
            ctrl_d.alu_op      = ALU_ADD;
            ctrl_d.alu_src_imm = 1'b1;
            ctrl_d.reg_write   = 1'b1;
         end
         OPC_JAL: begin
            imm_type           = IMM_J;
            ctrl_d.alu_op      = ALU_ADD;
            ctrl_d.alu_src_imm = 1'b1;
            ctrl_d.reg_write   = 1'b1;
            ctrl_d.jump        = 1'b1;
         end
         OPC_JALR: begin
            ctrl_d.alu_op      = ALU_ADD;
            ctrl_d.alu_src_imm = 1'b1;
            ctrl_d.reg_write   = 1'b1;
            ctrl_d.jump        = 1'b1;
            ctrl_d.illegal     = (funct3 != 3'b000);
         end
         OPC_BRANCH: begin
            imm_type      = IMM_B;
            ctrl_d.branch = 1'b1;
            case (funct3)
               3'b000, 3'b001: ctrl_d.alu_op = ALU_SUB;
               3'b100, 3'b101: ctrl_d.alu_op = ALU_SLT;
               3'b110, 3'b111: ctrl_d.alu_op = ALU_SLTU;
               default:        ctrl_d.illegal = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            ctrl_d.alu_op      = ALU_ADD;
            ctrl_d.alu_src_imm = 1'b1;
            ctrl_d.reg_write   = 1'b1;
            ctrl_d.mem_read    = 1'b1;
            ctrl_d.illegal     = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OPC_STORE: begin
            imm_type           = IMM_S;
            ctrl_d.alu_op      = ALU_ADD;
            ctrl_d.alu_src_imm = 1'b1;
            ctrl_d.mem_write   = 1'b1;
            ctrl_d.illegal     = (funct3 > 3'b010);
         end
         OPC_OPIMM: begin
            ctrl_d.alu_op      = alu_from_f3(funct3, (funct3 == 3'b101) && in_IR[30]);
            ctrl_d.alu_src_imm = 1'b1;
            ctrl_d.reg_write   = 1'b1;
            if (funct3 == 3'b001)
               ctrl_d.illegal = (funct7 != 7'h00);
            else if (funct3 == 3'b101)
               ctrl_d.illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
         end
         OPC_OP: begin
            ctrl_d.reg_write = 1'b1;
            if (funct7 == 7'h00)
               ctrl_d.alu_op = alu_from_f3(funct3, 1'b0);
            else if ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
               ctrl_d.alu_op = alu_from_f3(funct3, 1'b1);
`ifdef DECODE_MEXT_EN
            else if (funct7 == 7'h01)
               ctrl_d.alu_op = alu_op_t'({2'b10, funct3});
`endif
            else
               ctrl_d.illegal = 1'b1;
         end
         default: ctrl_d.illegal = 1'b1;
      endcase
      // an illegal instruction carries no control besides the illegal flag
      if (ctrl_d.illegal) begin
         ctrl_d         = '0;
         ctrl_d.illegal = 1'b1;
      end
      if (in_IR[11:7] == 5'd0)
         ctrl_d.reg_write = 1'b0;
   end

   // pipeline register: reset > flush > transfer > drain > hold
   always_ff @(posedge clk1) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_PC    <= '0;
         rs1_addr  <= '0;
         rs2_addr  <= '0;
         rd_addr   <= '0;
         imm       <= '0;
         ctrl_q    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_PC    <= in_PC;
         rs1_addr  <= in_IR[19:15];
         rs2_addr  <= in_IR[24:20];
         rd_addr   <= in_IR[11:7];
         imm       <= imm_d;
         ctrl_q    <= ctrl_d;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign alu_op      = ctrl_q.alu_op;
   assign alu_src_imm = ctrl_q.alu_src_imm;
   assign reg_write   = ctrl_q.reg_write;
   assign mem_read    = ctrl_q.mem_read;
   assign mem_write   = ctrl_q.mem_write;
   assign branch      = ctrl_q.branch;
   assign jump        = ctrl_q.jump;
   assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage (DECODE_MEXT_EN selects MUL expectation)
import riscv_defs_pkg::*;

module tb_decode_stage;

   logic          clk1;
   logic          rst;
   logic [31:0]   in_IR;
   logic [31:0]   in_PC;
   logic          in_valid;
   logic          in_ready;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_PC;
   logic [4:0]    rs1_addr;
   logic [4:0]    rs2_addr;
   logic [4:0]    rd_addr;
   logic [31:0]   imm;
   alu_op_t       alu_op;
   logic          alu_src_imm;
   logic          reg_write;
   logic          mem_read;
   logic          mem_write;
   logic          branch;
   logic          jump;
   logic          illegal;

   int checks = 0;
   int errors = 0;

   decode_stage dut (
      .clk1        (clk1),
      .rst         (rst),
      .in_IR       (in_IR),
      .in_PC       (in_PC),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_PC      (out_PC),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rd_addr     (rd_addr),
      .imm         (imm),
      .alu_op      (alu_op),
      .alu_src_imm (alu_src_imm),
      .reg_write   (reg_write),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .branch      (branch),
      .jump        (jump),
      .illegal     (illegal)
   );

   initial begin
      clk1 = 1'b0;
      forever #5 clk1 = ~clk1;
   end

   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   task automatic drive_one(input logic [31:0] ir, input logic [31:0] pc);
      in_IR     = ir;
      in_PC     = pc;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h exp 1", in_ready); end
      checks++;
      if ({out_PC, rs1_addr, rs2_addr, rd_addr, imm, alu_op, alu_src_imm, reg_write,
           mem_read, mem_write, branch, jump, illegal} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got pc=%h imm=%h rd=%0d alu=%0d illegal=%0b exp all 0",
                  out_PC, imm, rd_addr, alu_op, illegal);
      end
      rst = 1'b0;
   endtask

   task automatic test_addi();
      drive_one(32'h00500093, 32'h0000_0100);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0h exp 1", out_valid); end
      checks++; if (rd_addr !== 5'd1) begin errors++; $display("FAIL addi_rd got %0d exp 1", rd_addr); end
      checks++; if (rs1_addr !== 5'd0) begin errors++; $display("FAIL addi_rs1 got %0d exp 0", rs1_addr); end
      checks++; if (imm !== 32'd5) begin errors++; $display("FAIL addi_imm got %h exp 5", imm); end
      checks++; if (alu_op !== ALU_ADD) begin errors++; $display("FAIL addi_alu_op got %0d exp %0d", alu_op, ALU_ADD); end
      checks++; if ({alu_src_imm, reg_write, illegal} !== 3'b110) begin errors++; $display("FAIL addi_ctrl got %b exp 110", {alu_src_imm, reg_write, illegal}); end
      checks++; if (out_PC !== 32'h100) begin errors++; $display("FAIL addi_pc got %h exp 100", out_PC); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %0h exp 0", out_valid); end
   endtask

   task automatic test_backpressure();
      in_IR = 32'h00500093; in_PC = 32'h100; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_IR = 32'h007302B3; in_PC = 32'h104;
      for (int i = 0; i < 3; i++) begin
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0h exp 0", i, in_ready); end
         checks++;
         if ({out_valid, rd_addr, imm, out_PC} !== {1'b1, 5'd1, 32'd5, 32'h100}) begin
            errors++;
            $display("FAIL bp_hold[%0d] got v=%0b rd=%0d imm=%h pc=%h exp v=1 rd=1 imm=5 pc=100", i, out_valid, rd_addr, imm, out_PC);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0h exp 1", in_ready); end
      step();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, rd_addr, rs1_addr, rs2_addr, alu_src_imm, reg_write, out_PC} !==
          {1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b1, 32'h104}) begin
         errors++;
         $display("FAIL bp_second got v=%0b rd=%0d rs1=%0d rs2=%0d src=%0b rw=%0b pc=%h exp 1/5/6/7/0/1/104",
                  out_valid, rd_addr, rs1_addr, rs2_addr, alu_src_imm, reg_write, out_PC);
      end
      checks++; if (alu_op !== ALU_ADD) begin errors++; $display("FAIL bp_alu_op got %0d exp %0d", alu_op, ALU_ADD); end
      step();
   endtask

   task automatic test_branch();
      drive_one(32'hFE000EE3, 32'h200);
      checks++; if (branch !== 1'b1) begin errors++; $display("FAIL beq_branch got %0h exp 1", branch); end
      checks++; if (imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm got %h exp fffffffc", imm); end
      checks++; if ({reg_write, jump, alu_src_imm} !== 3'b000) begin errors++; $display("FAIL beq_ctrl got %b exp 000", {reg_write, jump, alu_src_imm}); end
      checks++; if (alu_op !== ALU_SUB) begin errors++; $display("FAIL beq_alu_op got %0d exp %0d", alu_op, ALU_SUB); end
   endtask

   task automatic test_store_lui_x0();
      drive_one(32'h0020A423, 32'h300);
      checks++;
      if ({mem_write, mem_read, reg_write, alu_src_imm, imm} !== {4'b1001, 32'd8}) begin
         errors++;
         $display("FAIL sw got mw=%0b mr=%0b rw=%0b src=%0b imm=%h exp 1/0/0/1/8", mem_write, mem_read, reg_write, alu_src_imm, imm);
      end
      drive_one(32'h12345137, 32'h304);
      checks++;
      if ({imm, rd_addr, reg_write} !== {32'h12345000, 5'd2, 1'b1}) begin
         errors++;
         $display("FAIL lui got imm=%h rd=%0d rw=%0b exp 12345000/2/1", imm, rd_addr, reg_write);
      end
      checks++; if (alu_op !== ALU_COPYB) begin errors++; $display("FAIL lui_alu_op got %0d exp %0d", alu_op, ALU_COPYB); end
      drive_one(32'h00100013, 32'h308);
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL x0_reg_write got %0b exp 0", reg_write); end
      step();
   endtask

   task automatic test_flush();
      in_IR = 32'h00500093; in_PC = 32'h400; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_same_cycle got %0h exp 0", out_valid); end
      in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stall got %0h exp 0", out_valid); end
   endtask

   task automatic test_illegal();
      drive_one(32'hFFFFFFFF, 32'h500);
      checks++; if ({out_valid, illegal} !== 2'b11) begin errors++; $display("FAIL ill_flag got v=%0b ill=%0b exp 1/1", out_valid, illegal); end
      checks++;
      if ({alu_op, alu_src_imm, reg_write, mem_read, mem_write, branch, jump} !== '0) begin
         errors++;
         $display("FAIL ill_ctrl got alu=%0d src=%0b rw=%0b mr=%0b mw=%0b br=%0b j=%0b exp all 0",
                  alu_op, alu_src_imm, reg_write, mem_read, mem_write, branch, jump);
      end
      checks++; if (rd_addr !== 5'd31) begin errors++; $display("FAIL ill_raw_rd got %0d exp 31", rd_addr); end
   endtask

   task automatic test_mext();
      drive_one(32'h022081B3, 32'h600);
`ifdef DECODE_MEXT_EN
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL mul_illegal got %0b exp 0", illegal); end
      checks++; if (alu_op !== ALU_MUL) begin errors++; $display("FAIL mul_alu_op got %0d exp %0d", alu_op, ALU_MUL); end
      checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL mul_reg_write got %0b exp 1", reg_write); end
`else
      checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL mul_illegal got %0b exp 1", illegal); end
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL mul_reg_write got %0b exp 0", reg_write); end
`endif
      step();
   endtask

   task automatic test_reset_mid_stall();
      in_IR = 32'h00500093; in_PC = 32'h700; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if ({out_valid, rd_addr, imm} !== '0) begin errors++; $display("FAIL rst_stall got v=%0b rd=%0d imm=%h exp 0", out_valid, rd_addr, imm); end
   endtask

   initial begin
      rst = 1'b1; in_IR = '0; in_PC = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      test_reset();
      test_addi();
      test_backpressure();
      test_branch();
      test_store_lui_x0();
      test_flush();
      test_illegal();
      test_mext();
      test_reset_mid_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
